// File: rtl/sha256_round_engine_if.sv
// ==== sha256_if : start/data/result bundle for the SHA-256 round engine ====
// Rev 1.0  initial release
`default_nettype none

interface sha256_if;
  logic         start;
  logic [255:0] h_in;
  logic [511:0] block_in;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;

  modport master (
    output start, h_in, block_in,
    input  busy, done, hash_out
  );

  modport slave (
    input  start, h_in, block_in,
    output busy, done, hash_out
  );
endinterface

`default_nettype wire

// File: rtl/sha256_round_engine.sv
// ==== sha256_round_engine : SHA-256 compression core, RPC rounds per clock ====
// Rev 1.0  initial release
`default_nettype none

module sha256_round_engine #(
  parameter int RPC   = 1,
  parameter int ACCUM = 1
) (
  input  logic     clk,
  input  logic     reset,
  sha256_if.slave  bus
);

  generate
    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_rpc_check
      $error("sha256_round_engine: RPC must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [5:0] T_LAST = 6'(64 - RPC);
  localparam logic [5:0] T_STEP = 6'(RPC);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  t;
  logic [31:0] vars     [8];
  logic [31:0] saved    [8];
  logic [31:0] win      [16];
  logic [31:0] vars_nxt [8];
  logic [31:0] win_nxt  [16];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] sml_s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // win[0] is always W[t]; each round consumes it and appends W[t+16].
  always_comb begin
    logic [31:0] va [8];
    logic [31:0] wv [16];
    logic [31:0] t1, t2, wn;
    for (int j = 0; j < 8; j++)  va[j] = vars[j];
    for (int j = 0; j < 16; j++) wv[j] = win[j];
    for (int i = 0; i < RPC; i++) begin
      t1 = va[7] + big_s1(va[4]) + ((va[4] & va[5]) ^ (~va[4] & va[6]))
         + K[t + 6'(i)] + wv[0];
      t2 = big_s0(va[0]) + ((va[0] & va[1]) ^ (va[0] & va[2]) ^ (va[1] & va[2]));
      wn = sml_s1(wv[14]) + wv[9] + sml_s0(wv[1]) + wv[0];
      for (int j = 7; j > 0; j--) va[j] = va[j-1];
      va[4] = va[4] + t1;
      va[0] = t1 + t2;
      for (int j = 0; j < 15; j++) wv[j] = wv[j+1];
      wv[15] = wn;
    end
    vars_nxt = va;
    win_nxt  = wv;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      t            <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.hash_out <= '0;
      for (int j = 0; j < 8; j++) begin
        vars[j]  <= '0;
        saved[j] <= '0;
      end
      for (int j = 0; j < 16; j++) win[j] <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle is still treated as part of the finishing block.
          if (bus.start && !bus.done) begin
            for (int j = 0; j < 8; j++) begin
              vars[j]  <= bus.h_in[255 - 32*j -: 32];
              saved[j] <= bus.h_in[255 - 32*j -: 32];
            end
            for (int j = 0; j < 16; j++) win[j] <= bus.block_in[511 - 32*j -: 32];
            t        <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          vars <= vars_nxt;
          win  <= win_nxt;
          if (t == T_LAST) state <= FINAL;
          else             t     <= t + T_STEP;
        end
        FINAL: begin
          for (int j = 0; j < 8; j++)
            bus.hash_out[255 - 32*j -: 32] <= (ACCUM != 0) ? saved[j] + vars[j] : vars[j];
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256_round_engine.sv
// Bench for sha256_round_engine: five instances (RPC 1/2/4/8 accumulating, RPC 1 raw)
// checked against known digests and a plain SHA-256 compression model.
`default_nettype none

module tb_sha256_round_engine;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_CHAIN = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_C1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_C2    = {480'h0, 32'h000001c0};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [4:0]   start_v = '0;
  logic [255:0] h_in = '0;
  logic [511:0] block_in = '0;
  logic [4:0]   busy_v;
  logic [4:0]   done_v;
  logic [255:0] hash_v [5];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sha256_if bus ();
    assign bus.start    = start_v[g];
    assign bus.h_in     = h_in;
    assign bus.block_in = block_in;
    assign busy_v[g]    = bus.busy;
    assign done_v[g]    = bus.done;
    assign hash_v[g]    = bus.hash_out;
    sha256_round_engine #(
      .RPC   ((g == 4) ? 1 : (1 << g)),
      .ACCUM ((g == 4) ? 0 : 1)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  function automatic int rpc_of(input int k);
    return (k == 4) ? 1 : (1 << k);
  endfunction

  function automatic bit acc_of(input int k);
    return k != 4;
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Straightforward SHA-256 compression: full 64-word schedule, then 64 rounds.
  function automatic logic [255:0] model(input logic [255:0] h, input logic [511:0] blk, input bit accum);
    logic [31:0]  w [64];
    logic [31:0]  hv [8];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      hv[i] = h[255 - 32*i -: 32];
      v[i]  = hv[i];
    end
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = blk[511 - 32*i -: 32];
      else w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    end
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++)
      r[255 - 32*i -: 32] = accum ? hv[i] + v[i] : v[i];
    return r;
  endfunction

  function automatic logic [255:0] sub_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] - y[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // One block on DUT k; optional ignored start pulses mid-run and in the done cycle.
  task automatic run_block(input int k, input logic [255:0] h, input logic [511:0] blk,
                           input logic [255:0] exp, input string nm,
                           input bit mid_pulse, input bit done_pulse);
    int cnt;
    int dones;
    int lat;
    lat = 64 / rpc_of(k) + 1;
    @(negedge clk);
    h_in = h; block_in = blk; start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0; h_in = rnd256(); block_in = rnd512();
    chk($sformatf("%s_busy_k%0d", nm, k), {255'b0, busy_v[k]}, 256'd1);
    cnt = 1;
    while (!done_v[k] && cnt < 300) begin
      start_v[k] = (mid_pulse && cnt == 3);
      @(negedge clk);
      cnt++;
    end
    start_v[k] = 1'b0;
    chk($sformatf("%s_latency_k%0d", nm, k), 256'(cnt), 256'(lat + 1));
    chk($sformatf("%s_hash_k%0d", nm, k), hash_v[k], exp);
    chk($sformatf("%s_busy_in_done_k%0d", nm, k), {255'b0, busy_v[k]}, 256'd0);
    if (done_pulse) begin
      start_v[k] = 1'b1; h_in = rnd256(); block_in = rnd512();
    end
    @(negedge clk);
    start_v[k] = 1'b0;
    chk($sformatf("%s_done_width_k%0d", nm, k), {255'b0, done_v[k]}, 256'd0);
    if (done_pulse) begin
      chk($sformatf("%s_ignored_start_k%0d", nm, k), {255'b0, busy_v[k]}, 256'd0);
      dones = 0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (done_v[k]) dones++;
      end
      chk($sformatf("%s_no_extra_done_k%0d", nm, k), 256'(dones), 256'd0);
      chk($sformatf("%s_hash_held_k%0d", nm, k), hash_v[k], exp);
    end
  endtask

  typedef struct {
    logic [255:0] h;
    logic [511:0] blk;
    logic [255:0] exp;
    string        nm;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [255:0] d1;
    logic [255:0] exp;
    logic [255:0] h;
    logic [511:0] blk;
    int dones;

    d1 = model(IV, B_C1, 1'b1);
    tbl[0] = '{h: IV, blk: B_ABC,   exp: D_ABC,   nm: "abc"};
    tbl[1] = '{h: IV, blk: B_EMPTY, exp: D_EMPTY, nm: "empty"};
    tbl[2] = '{h: IV, blk: B_C1,    exp: d1,      nm: "chain1"};
    tbl[3] = '{h: d1, blk: B_C2,    exp: D_CHAIN, nm: "chain2"};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("reset_busy_k%0d", k), {255'b0, busy_v[k]}, 256'd0);
      chk($sformatf("reset_done_k%0d", k), {255'b0, done_v[k]}, 256'd0);
      chk($sformatf("reset_hash_k%0d", k), hash_v[k], 256'd0);
    end
    reset = 1'b0;

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 5; k++) begin
        if (acc_of(k))  exp = tbl[r].exp;
        else if (r == 0) exp = sub_words(D_ABC, IV);
        else            exp = model(tbl[r].h, tbl[r].blk, 1'b0);
        run_block(k, tbl[r].h, tbl[r].blk, exp, tbl[r].nm, 1'b0, 1'b0);
      end
    end

    for (int k = 0; k < 4; k++)
      run_block(k, IV, B_ABC, D_ABC, "ignore", 1'b1, 1'b1);

    // Reset 20 cycles into an RPC=1 block.
    @(negedge clk);
    h_in = IV; block_in = B_ABC; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (19) @(negedge clk);
    chk("abort_busy_before", {255'b0, busy_v[0]}, 256'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {255'b0, busy_v[0]}, 256'd0);
    chk("abort_hash", hash_v[0], 256'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    chk("abort_no_done", 256'(dones), 256'd0);
    run_block(0, IV, B_ABC, D_ABC, "after_abort", 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 5; k++) begin
        h   = rnd256();
        blk = rnd512();
        run_block(k, h, blk, model(h, blk, acc_of(k)), "rand", 1'b0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
